// File: rtl/gmii_tx_checker.sv
// gmii_tx_checker: passive GMII TX monitor that parses each frame, checks FCS, lengths,
// ethertype, TXER and inter-frame gap, and reports a per-frame status pulse plus counters.
module gmii_tx_checker #(
  parameter logic [15:0] EXP_ETHERTYPE = 16'h0800,
  parameter int unsigned MIN_FRAME     = 64,
  parameter int unsigned MAX_FRAME     = 1518,
  parameter int unsigned MIN_IFG       = 12
) (
  input  logic        GMII_GTXCLK,
  input  logic        rst_n,
  input  logic [7:0]  GMII_TXD,
  input  logic        GMII_TXEN,
  input  logic        GMII_TXER,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        preamble_err,
  output logic        crc_err,
  output logic        len_err,
  output logic        type_err,
  output logic        txer_err,
  output logic        gap_err,
  output logic [10:0] frame_len,
  output logic [15:0] frame_cnt,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);
  typedef enum logic [2:0] {SYNC, IDLE, PREAMBLE, BODY, DROP} state_e;
  localparam logic [10:0] MIN_L = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME);
  localparam logic [7:0]  IFG_L = 8'(MIN_IFG);
  state_e      state_q;
  logic [7:0]  idle_q;
  logic        first_q, gap_q, txer_q;
  logic [2:0]  pre_q;
  logic [10:0] idx_q;
  logic [31:0] crc_q, crc_d;
  logic [15:0] etype_q, ip_q, udp_q;
  logic        in_body, fin, b_crc, b_type, b_len, ok;
  always_comb begin
    crc_d = crc_q ^ {24'd0, GMII_TXD};
    for (int i = 0; i < 8; i++) crc_d = crc_d[0] ? (crc_d >> 1) ^ 32'hEDB88320 : crc_d >> 1;
  end
  assign in_body = state_q == BODY;
  assign fin     = !GMII_TXEN && (state_q == PREAMBLE || in_body || state_q == DROP);
  assign b_crc   = crc_q != 32'hDEBB20E3 || idx_q < 11'd4;
  assign b_type  = idx_q >= 11'd14 && etype_q != EXP_ETHERTYPE;
  // IPv4 frames must also agree with their own IP and UDP length fields
  assign b_len   = idx_q < MIN_L || idx_q > MAX_L ||
                   (etype_q == 16'h0800 && ({1'b0, ip_q} + 17'd18 != {6'd0, idx_q} ||
                                            {1'b0, udp_q} + 17'd20 != {1'b0, ip_q}));
  assign ok      = in_body && !(b_crc || b_type || b_len || txer_q || gap_q);
  always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      idle_q       <= '0;
      first_q      <= 1'b1;
      gap_q        <= 1'b0;
      txer_q       <= 1'b0;
      pre_q        <= '0;
      idx_q        <= '0;
      crc_q        <= '1;
      etype_q      <= '0;
      ip_q         <= '0;
      udp_q        <= '0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      preamble_err <= 1'b0;
      crc_err      <= 1'b0;
      len_err      <= 1'b0;
      type_err     <= 1'b0;
      txer_err     <= 1'b0;
      gap_err      <= 1'b0;
      frame_len    <= '0;
      frame_cnt    <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        SYNC: if (!GMII_TXEN) begin
          state_q <= IDLE;
          idle_q  <= 8'd1;
          first_q <= 1'b1;
        end
        IDLE: if (GMII_TXEN) begin
          gap_q   <= !first_q && idle_q < IFG_L;
          first_q <= 1'b0;
          pre_q   <= 3'd1;
          state_q <= GMII_TXD == 8'h55 ? PREAMBLE : DROP;
        end else if (idle_q != 8'hFF) begin
          idle_q <= idle_q + 8'd1;
        end
        PREAMBLE: if (GMII_TXEN) begin
          if (GMII_TXD == 8'h55 && pre_q != 3'd7) begin
            pre_q <= pre_q + 3'd1;
          end else if (GMII_TXD == 8'hD5 && pre_q == 3'd7) begin
            state_q <= BODY;
            crc_q   <= '1;
            idx_q   <= '0;
            etype_q <= '0;
            ip_q    <= '0;
            udp_q   <= '0;
            txer_q  <= 1'b0;
          end else begin
            state_q <= DROP;
          end
        end
        BODY: if (GMII_TXEN) begin
          crc_q   <= crc_d;
          idx_q   <= idx_q == 11'h7FF ? idx_q : idx_q + 11'd1;
          etype_q <= idx_q == 11'd12 ? {GMII_TXD, etype_q[7:0]} :
                     idx_q == 11'd13 ? {etype_q[15:8], GMII_TXD} : etype_q;
          ip_q    <= idx_q == 11'd16 ? {GMII_TXD, ip_q[7:0]} :
                     idx_q == 11'd17 ? {ip_q[15:8], GMII_TXD} : ip_q;
          udp_q   <= idx_q == 11'd38 ? {GMII_TXD, udp_q[7:0]} :
                     idx_q == 11'd39 ? {udp_q[15:8], GMII_TXD} : udp_q;
          txer_q  <= txer_q | GMII_TXER;
        end
        default: ;
      endcase
      // Frames that never reached the body report only the preamble error and the gap flag
      if (fin) begin
        frame_done   <= 1'b1;
        frame_ok     <= ok;
        preamble_err <= !in_body;
        crc_err      <= in_body && b_crc;
        len_err      <= in_body && b_len;
        type_err     <= in_body && b_type;
        txer_err     <= in_body && txer_q;
        gap_err      <= gap_q;
        frame_len    <= in_body ? idx_q : '0;
        frame_cnt    <= frame_cnt + 16'd1;
        good_cnt     <= good_cnt + {15'd0, ok};
        bad_cnt      <= bad_cnt + {15'd0, !ok};
        state_q      <= IDLE;
        idle_q       <= 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_gmii_tx_checker.sv
// tb_gmii_tx_checker: directed and randomized GMII frames scored against a byte-level
// reference model that judges each frame from its preamble, FCS and header fields.
module tb_gmii_tx_checker;
  logic        clk = 1'b0, rst_n = 1'b0, txen = 1'b0, txer = 1'b0;
  logic [7:0]  txd = 8'h00;
  logic        frame_done, frame_ok, preamble_err, crc_err, len_err, type_err, txer_err, gap_err;
  logic [10:0] frame_len;
  logic [15:0] frame_cnt, good_cnt, bad_cnt;

  gmii_tx_checker dut (
    .GMII_GTXCLK(clk), .rst_n(rst_n), .GMII_TXD(txd), .GMII_TXEN(txen), .GMII_TXER(txer),
    .frame_done(frame_done), .frame_ok(frame_ok), .preamble_err(preamble_err),
    .crc_err(crc_err), .len_err(len_err), .type_err(type_err), .txer_err(txer_err),
    .gap_err(gap_err), .frame_len(frame_len), .frame_cnt(frame_cnt),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #4 clk = ~clk;

  int   n_cmp = 0, n_mis = 0, pulses = 0, exp_pulses = 0, fnum = 0;
  int   m_frames = 0, m_good = 0, m_bad = 0, e_len_v;
  bit   first = 1'b1;
  logic e_pre, e_crc, e_len, e_type, e_txer, e_gap, e_ok;
  logic [7:0] body[$], pkt[$];
  bit   er[$];

  always @(negedge clk) if (frame_done === 1'b1) pulses++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fcs(input logic [7:0] q[$], input int from, input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      c ^= {24'd0, q[from+i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction

  task automatic put16(input logic [15:0] v);
    body.push_back(v[15:8]);
    body.push_back(v[7:0]);
  endtask

  task automatic build(input int dsize, input bit rnd);
    body.delete();
    for (int i = 0; i < 12; i++) body.push_back(8'($urandom));
    put16(16'h0800); put16(16'h4500); put16(16'(28 + dsize)); put16(16'h0000);
    put16(16'h4000); put16(16'h4011); put16(16'h0000);
    for (int i = 0; i < 8; i++) body.push_back(8'($urandom));
    put16(16'($urandom)); put16(16'($urandom)); put16(16'(8 + dsize)); put16(16'h0000);
    for (int i = 0; i < dsize; i++) body.push_back(rnd ? 8'($urandom) : 8'hF0);
  endtask

  task automatic seal();
    logic [31:0] f;
    f = fcs(body, 0, body.size());
    body.push_back(f[7:0]); body.push_back(f[15:8]);
    body.push_back(f[23:16]); body.push_back(f[31:24]);
  endtask

  task automatic wrap(input int npre, input logic [7:0] sfd);
    pkt.delete(); er.delete();
    repeat (npre) pkt.push_back(8'h55);
    pkt.push_back(sfd);
    foreach (body[i]) pkt.push_back(body[i]);
    foreach (pkt[i]) er.push_back(1'b0);
  endtask

  // Judges a whole frame from its bytes: valid preamble is exactly seven 0x55 then 0xD5
  task automatic model(input int gap);
    int n, len;
    logic [15:0] et, ipl, udl;
    logic pre_ok;
    n = 0; et = '0;
    while (n < pkt.size() && pkt[n] == 8'h55) n++;
    pre_ok = n == 7 && pkt.size() >= 8 && pkt[7] == 8'hD5;
    e_gap = !first && gap < 12;
    first = 1'b0;
    {e_crc, e_len, e_type, e_txer} = '0;
    e_pre = !pre_ok;
    e_len_v = 0;
    if (pre_ok) begin
      len = pkt.size() - 8;
      if (len > 2047) len = 2047;
      e_len_v = len;
      if (len < 4) e_crc = 1'b1;
      else e_crc = fcs(pkt, 8, len - 4) !=
                   {pkt[8+len-1], pkt[8+len-2], pkt[8+len-3], pkt[8+len-4]};
      if (len >= 14) begin
        et = {pkt[20], pkt[21]};
        e_type = et != 16'h0800;
      end
      e_len = len < 64 || len > 1518;
      if (len >= 40 && et == 16'h0800) begin
        ipl = {pkt[24], pkt[25]};
        udl = {pkt[46], pkt[47]};
        if (int'(ipl) + 18 != len || int'(udl) + 20 != int'(ipl)) e_len = 1'b1;
      end
      for (int i = 8; i < pkt.size(); i++) if (er[i]) e_txer = 1'b1;
    end
    e_ok = !(e_pre || e_crc || e_len || e_type || e_txer || e_gap);
    m_frames++;
    if (e_ok) m_good++; else m_bad++;
    exp_pulses++;
  endtask

  task automatic drive(input logic en, input logic [7:0] d, input logic e);
    @(negedge clk);
    txen = en; txd = d; txer = e;
  endtask

  task automatic send(input int gap);
    model(gap);
    fnum++;
    repeat (gap - 1) drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < pkt.size(); i++) drive(1'b1, pkt[i], er[i]);
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk($sformatf("f%0d done", fnum), frame_done, 1);
    chk($sformatf("f%0d ok", fnum), frame_ok, e_ok);
    chk($sformatf("f%0d pre", fnum), preamble_err, e_pre);
    chk($sformatf("f%0d crc", fnum), crc_err, e_crc);
    chk($sformatf("f%0d len_err", fnum), len_err, e_len);
    chk($sformatf("f%0d type", fnum), type_err, e_type);
    chk($sformatf("f%0d txer", fnum), txer_err, e_txer);
    chk($sformatf("f%0d gap", fnum), gap_err, e_gap);
    chk($sformatf("f%0d frame_len", fnum), frame_len, e_len_v);
    chk($sformatf("f%0d frame_cnt", fnum), frame_cnt, 16'(m_frames));
    chk($sformatf("f%0d good_cnt", fnum), good_cnt, 16'(m_good));
    chk($sformatf("f%0d bad_cnt", fnum), bad_cnt, 16'(m_bad));
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, " done"}, frame_done, 0);
    chk({tag, " ok"}, frame_ok, 0);
    chk({tag, " pre"}, preamble_err, 0);
    chk({tag, " frame_len"}, frame_len, 0);
    chk({tag, " frame_cnt"}, frame_cnt, 0);
    chk({tag, " good_cnt"}, good_cnt, 0);
    chk({tag, " bad_cnt"}, bad_cnt, 0);
  endtask

  initial begin
    int kind, gap;
    repeat (3) @(posedge clk);
    #1 chk_clear("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    build(1472, 0); seal(); wrap(7, 8'hD5); send(1);
    build(1472, 0); seal(); body[42+100] ^= 8'h01; wrap(7, 8'hD5); send(12);
    build(100, 1); seal(); wrap(6, 8'hD5); send(12);
    build(1472, 0); seal(); wrap(7, 8'hD5); send(12);
    send(8);
    send(13);
    build(32, 0); body[16] = 8'h00; body[17] = 8'd61; seal(); wrap(7, 8'hD5); send(12);
    build(1472, 0); seal(); wrap(7, 8'hD5); er[8+50] = 1'b1; send(12);
    build(17, 1); seal(); wrap(7, 8'hD5); send(12);
    build(18, 1); seal(); wrap(7, 8'hD5); send(12);
    build(40, 1); seal(); wrap(7, 8'hD5); send(1);
    body.delete(); wrap(7, 8'hD5); send(12);
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 7);
      gap  = $urandom_range(1, 20);
      build($urandom_range(18, 300), 1);
      if (kind == 2) begin body[12] = 8'h86; body[13] = 8'hDD; end
      if (kind == 3) body[17] ^= 8'h01;
      if (kind == 4) body[39] ^= 8'h04;
      if (kind == 7) begin
        body.delete();
        repeat ($urandom_range(0, 20)) body.push_back(8'($urandom));
      end
      if (kind != 7 || $urandom_range(0, 1) == 1) seal();
      if (kind == 1) body[$urandom_range(0, body.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
      if (kind == 6) wrap($urandom_range(0, 9), $urandom_range(0, 1) == 1 ? 8'hD5 : 8'($urandom));
      else wrap(7, 8'hD5);
      if (kind == 5) er[$urandom_range(0, er.size() - 1)] = 1'b1;
      send(gap);
    end
    build(600, 1); seal(); wrap(7, 8'hD5);
    for (int i = 0; i < 300; i++) drive(1'b1, pkt[i], 1'b0);
    drive(1'b1, pkt[300], 1'b0);
    rst_n = 1'b0;
    #1 chk_clear("midreset");
    drive(1'b1, pkt[301], 1'b0);
    drive(1'b1, pkt[302], 1'b0);
    drive(1'b1, pkt[303], 1'b0);
    rst_n = 1'b1;
    for (int i = 304; i < pkt.size(); i++) drive(1'b1, pkt[i], 1'b0);
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    chk("no pulse for truncated frame", pulses, exp_pulses);
    first = 1'b1; m_frames = 0; m_good = 0; m_bad = 0;
    build(1472, 0); seal(); wrap(7, 8'hD5); send(12);
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    chk("pulse count", pulses, exp_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
